onehot_decoder_seq: RTL and testbench
=====================================

Name: onehot_decoder_seq

Overview:
- Parametrised, registered binary-to-one-hot decoder. Successor to the team's combinational 2-to-4 decoder.
- Accepts codes over a valid/ready handshake and drives a one-hot select bus.
- Two output modes: level (hold until replaced) and pulse (asserted for a fixed number of cycles).
- Flags out-of-range codes. Used as the select/strobe generator for chip-select and channel-enable fan-out.

Parameters:
- IN_W, 2, width of the input code.
- N_OUT, 4, number of one-hot outputs. Legal range 2..2^IN_W.
- PULSE_LEN, 4, cycles an output stays asserted in pulse mode. Must be 1 or more.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_code is valid this cycle.
- in_ready  out  1  block can accept a code this cycle.
- in_code  in  IN_W  binary code to decode.
- mode  in  1  0 = level, 1 = pulse. Sampled with the accepted code.
- en  in  1  decoder enable. When low, no codes are accepted.
- clear  in  1  synchronous clear of outputs, state and error.
- dec_out  out  N_OUT  registered one-hot select.
- out_valid  out  1  registered; high whenever dec_out is non-zero.
- err  out  1  sticky out-of-range flag.

Behaviour:
- Reset (rst_n low, asynchronous):
  - dec_out = 0, out_valid = 0, err = 0, state = IDLE, pulse counter = 0.
- States: IDLE, HOLD, PULSE.
- Ready and accept:
  - in_ready = en & ~clear & (state != PULSE). This is combinational from registered state and inputs.
  - Accept = in_valid & in_ready.
- Latency: one cycle. dec_out and out_valid update on the clock edge that accepts the code.
- Accepted code below N_OUT, mode 0:
  - dec_out <= 1 << in_code, state <= HOLD.
  - Holds until the next accepted code or clear.
- Accepted code below N_OUT, mode 1:
  - dec_out <= 1 << in_code, state <= PULSE, counter <= PULSE_LEN-1.
  - In PULSE, each cycle: if counter = 0, dec_out <= 0 and state <= IDLE; else counter decrements.
  - dec_out is therefore high for exactly PULSE_LEN cycles.
  - in_ready stays low for those PULSE_LEN cycles and rises in the cycle dec_out returns to 0.
  - Back-to-back pulses always have at least one all-zero cycle between them.
- Accepted code N_OUT or above:
  - The handshake completes (code consumed).
  - dec_out <= 0, state <= IDLE, err <= 1.
  - err stays set until clear or reset.
- HOLD state with a new accepted code: the output switches directly to the new one-hot value in one edge. There is no zero gap and never two bits set at once.
- clear high (highest priority after reset):
  - Next edge: dec_out = 0, state = IDLE, counter = 0, err = 0.
  - No accept can happen in that cycle because in_ready is low.
  - clear during a pulse aborts the pulse.
- en low:
  - No new accepts.
  - An active pulse still runs to completion; a held level output is retained.
- Reset mid-pulse: outputs clear immediately (asynchronously). The block restarts in IDLE.
- Invariants:
  - dec_out is always zero or one-hot.
  - out_valid == |dec_out at all times.
  - With PULSE_LEN = 1, the output is a single-cycle strobe.
- Counter width = $clog2(PULSE_LEN+1). Counter arithmetic is unsigned with no wrap: it is reloaded on accept and never decrements below 0.

Decomposition:
- Shared package holds:
  - State encoding localparams: IDLE = 2'd0, HOLD = 2'd1, PULSE = 2'd2.
  - Mode constants: MODE_LEVEL = 0, MODE_PULSE = 1.
- Sub-module pulse_timer: a loadable down-counter with load, value and done signals, parametrised by PULSE_LEN.
- The one-hot decode itself stays inline.

Test Plan:
- Reset, then level mode: codes 0,1,2,3 in consecutive cycles with en=1 → dec_out = 0001, 0010, 0100, 1000, each one cycle after accept; in_ready stays 1 throughout.
- Pulse mode, PULSE_LEN=4: code 2 → dec_out = 0100 for exactly 4 cycles, then 0000. in_ready is low for those 4 cycles. A code 1 held valid during the pulse is accepted only after the pulse ends, giving 0010 after one zero cycle.
- IN_W=3, N_OUT=5: code 6 → err = 1, dec_out = 0, in_ready stays high. A following code 4 → dec_out = 10000 while err stays 1. clear → err = 0, dec_out = 0.
- Mid-pulse abort: clear asserted in the 2nd pulse cycle → dec_out = 0 on the next edge, state IDLE, in_ready = 1 after clear deasserts. Separately, rst_n low mid-pulse → outputs zero immediately, without waiting for a clock edge.
- en=0 with in_valid=1 and code 3 → in_ready = 0 and dec_out unchanged (holds 0010 from an earlier level command). Raising en → 1000 on the next edge.
- PULSE_LEN=1: back-to-back pulse requests for code 0 → pattern 0001, 0000, 0001, 0000. out_valid tracks |dec_out every cycle.

Source files
------------

// File: rtl/onehot_decoder_seq_pkg.sv
// Shared types and constants for the registered one-hot decoder.
package onehot_decoder_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    PULSE = 2'd2
  } state_t;

  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_PULSE = 1'b1;

endpackage

// File: rtl/onehot_decoder_seq_pulse_timer.sv
// Loadable down-counter that sets the high time of a pulse-mode output.
module pulse_timer #(
  parameter int unsigned PULSE_LEN = 4,
  localparam int unsigned CNT_W = $clog2(PULSE_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic             dec,
  output logic [CNT_W-1:0] value,
  output logic             done_c
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(PULSE_LEN - 1);

  // Saturates at zero; only a load moves it back up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (load) begin
      value <= LOAD_VAL;
    end else if (dec && (value != '0)) begin
      value <= value - CNT_W'(1);
    end
  end

  assign done_c = (value == '0);

endmodule

// File: rtl/onehot_decoder_seq.sv
// Registered binary-to-one-hot decoder with valid/ready intake and level or
// fixed-length pulse output modes; out-of-range codes raise a sticky error.
module onehot_decoder_seq
  import onehot_decoder_seq_pkg::*;
#(
  parameter int unsigned IN_W      = 2,
  parameter int unsigned N_OUT     = 4,
  parameter int unsigned PULSE_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_code,
  input  logic             mode,
  input  logic             en,
  input  logic             clear,
  output logic [N_OUT-1:0] dec_out,
  output logic             out_valid,
  output logic             err
);

  localparam int unsigned CODE_W = IN_W + 1;
  localparam int unsigned CNT_W  = $clog2(PULSE_LEN + 1);

  state_t             state, state_nxt;
  logic [N_OUT-1:0]   dec_nxt;
  logic               err_nxt;
  logic               accept_c;
  logic               in_range_c;
  logic [N_OUT-1:0]   onehot_c;
  logic               tmr_load;
  logic               tmr_dec;
  logic               tmr_done_c;
  logic [CNT_W-1:0]   tmr_value;

  assign in_ready   = en & ~clear & (state != PULSE);
  assign accept_c   = in_valid & in_ready;
  // Extra bit so N_OUT == 2**IN_W is representable in the compare.
  assign in_range_c = ({1'b0, in_code} < CODE_W'(N_OUT));
  assign onehot_c   = N_OUT'(1) << in_code;

  pulse_timer #(.PULSE_LEN(PULSE_LEN)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear),
    .load   (tmr_load),
    .dec    (tmr_dec),
    .value  (tmr_value),
    .done_c (tmr_done_c)
  );

  // Next-state and next-output decode.
  always_comb begin
    state_nxt = state;
    dec_nxt   = dec_out;
    err_nxt   = err;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    if (clear) begin
      state_nxt = IDLE;
      dec_nxt   = '0;
      err_nxt   = 1'b0;
    end else if (state == PULSE) begin
      if (tmr_done_c) begin
        state_nxt = IDLE;
        dec_nxt   = '0;
      end else begin
        tmr_dec = 1'b1;
      end
    end else if (accept_c) begin
      if (in_range_c) begin
        dec_nxt = onehot_c;
        if (mode == MODE_PULSE) begin
          state_nxt = PULSE;
          tmr_load  = 1'b1;
        end else begin
          state_nxt = HOLD;
        end
      end else begin
        state_nxt = IDLE;
        dec_nxt   = '0;
        err_nxt   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dec_out   <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      dec_out   <= dec_nxt;
      out_valid <= |dec_nxt;
      err       <= err_nxt;
    end
  end

  // The timer only holds a non-zero count while a pulse is running.
  a_timer_idle : assert property (@(posedge clk) disable iff (!rst_n)
    (state != PULSE) |-> (tmr_value == '0));

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Directed bench for onehot_decoder_seq: default, 3-bit/5-output and
// single-cycle-pulse instances.
module tb_onehot_decoder_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: IN_W=2, N_OUT=4, PULSE_LEN=4
  logic       a_valid, a_ready, a_mode, a_en, a_clear, a_ov, a_err;
  logic [1:0] a_code;
  logic [3:0] a_dec;
  // Instance B: IN_W=3, N_OUT=5, PULSE_LEN=4
  logic       b_valid, b_ready, b_mode, b_en, b_clear, b_ov, b_err;
  logic [2:0] b_code;
  logic [4:0] b_dec;
  // Instance C: IN_W=2, N_OUT=4, PULSE_LEN=1
  logic       c_valid, c_ready, c_mode, c_en, c_clear, c_ov, c_err;
  logic [1:0] c_code;
  logic [3:0] c_dec;

  onehot_decoder_seq #(.IN_W(2), .N_OUT(4), .PULSE_LEN(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready),
    .in_code(a_code), .mode(a_mode), .en(a_en), .clear(a_clear),
    .dec_out(a_dec), .out_valid(a_ov), .err(a_err));

  onehot_decoder_seq #(.IN_W(3), .N_OUT(5), .PULSE_LEN(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready),
    .in_code(b_code), .mode(b_mode), .en(b_en), .clear(b_clear),
    .dec_out(b_dec), .out_valid(b_ov), .err(b_err));

  onehot_decoder_seq #(.IN_W(2), .N_OUT(4), .PULSE_LEN(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_valid), .in_ready(c_ready),
    .in_code(c_code), .mode(c_mode), .en(c_en), .clear(c_clear),
    .dec_out(c_dec), .out_valid(c_ov), .err(c_err));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle: out_valid mirrors |dec_out and dec_out is zero or one-hot.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("inv_ov_a", 32'(a_ov), 32'(|a_dec));
      chk("inv_ov_b", 32'(b_ov), 32'(|b_dec));
      chk("inv_ov_c", 32'(c_ov), 32'(|c_dec));
      chk("inv_1h_a", 32'($onehot0(a_dec)), 32'd1);
      chk("inv_1h_b", 32'($onehot0(b_dec)), 32'd1);
      chk("inv_1h_c", 32'($onehot0(c_dec)), 32'd1);
    end
  end

  typedef struct {
    logic       valid;
    logic [1:0] code;
    logic       mode;
    logic       en;
    logic       clear;
    logic       exp_ready;
    logic [3:0] exp_dec;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_vec(input int i, input logic v, input logic [1:0] c, input logic m,
                         input logic e, input logic cl, input logic r, input logic [3:0] d);
    vecs[i].valid = v; vecs[i].code = c; vecs[i].mode = m; vecs[i].en = e;
    vecs[i].clear = cl; vecs[i].exp_ready = r; vecs[i].exp_dec = d;
  endtask

  initial begin
    //            v  code  m  en clr rdy dec
    set_vec( 0, 1, 2'd0, 0, 1, 0, 1, 4'b0001);
    set_vec( 1, 1, 2'd1, 0, 1, 0, 1, 4'b0010);
    set_vec( 2, 1, 2'd2, 0, 1, 0, 1, 4'b0100);
    set_vec( 3, 1, 2'd3, 0, 1, 0, 1, 4'b1000);
    set_vec( 4, 1, 2'd2, 1, 1, 0, 1, 4'b0100); // pulse starts
    set_vec( 5, 1, 2'd1, 0, 1, 0, 0, 4'b0100);
    set_vec( 6, 1, 2'd1, 0, 1, 0, 0, 4'b0100);
    set_vec( 7, 1, 2'd1, 0, 1, 0, 0, 4'b0100);
    set_vec( 8, 1, 2'd1, 0, 1, 0, 0, 4'b0000); // pulse ends
    set_vec( 9, 1, 2'd1, 0, 1, 0, 1, 4'b0010); // pending code accepted
    set_vec(10, 1, 2'd3, 0, 0, 0, 0, 4'b0010); // en low: hold
    set_vec(11, 1, 2'd3, 0, 1, 0, 1, 4'b1000);
    set_vec(12, 0, 2'd0, 0, 1, 0, 1, 4'b1000);
    set_vec(13, 1, 2'd0, 0, 1, 1, 0, 4'b0000); // clear wins
    set_vec(14, 0, 2'd0, 0, 1, 0, 1, 4'b0000);
    set_vec(15, 1, 2'd1, 1, 1, 0, 1, 4'b0010); // pulse, first cycle
    set_vec(16, 0, 2'd0, 0, 1, 1, 0, 4'b0000); // abort in 2nd cycle
    set_vec(17, 0, 2'd0, 0, 1, 0, 1, 4'b0000);
    set_vec(18, 1, 2'd3, 1, 1, 0, 1, 4'b1000); // pulse, then en low
    set_vec(19, 0, 2'd0, 0, 0, 0, 0, 4'b1000);
    set_vec(20, 0, 2'd0, 0, 0, 0, 0, 4'b1000);
    set_vec(21, 0, 2'd0, 0, 0, 0, 0, 4'b1000);
    set_vec(22, 0, 2'd0, 0, 0, 0, 0, 4'b0000);
    set_vec(23, 0, 2'd0, 0, 0, 0, 0, 4'b0000);

    a_valid = 0; a_code = '0; a_mode = 0; a_en = 1; a_clear = 0;
    b_valid = 0; b_code = '0; b_mode = 0; b_en = 1; b_clear = 0;
    c_valid = 0; c_code = '0; c_mode = 0; c_en = 1; c_clear = 0;

    // Reset state
    rst_n = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_dec_a", 32'(a_dec), 32'd0);
    chk("rst_ov_a",  32'(a_ov),  32'd0);
    chk("rst_err_a", 32'(a_err), 32'd0);
    chk("rst_dec_b", 32'(b_dec), 32'd0);
    chk("rst_err_b", 32'(b_err), 32'd0);
    chk("rst_dec_c", 32'(c_dec), 32'd0);
    rst_n = 1;
    step();

    // Table for instance A
    for (int i = 0; i < NV; i++) begin
      a_valid = vecs[i].valid; a_code = vecs[i].code; a_mode = vecs[i].mode;
      a_en = vecs[i].en; a_clear = vecs[i].clear;
      #1;
      chk($sformatf("a_ready[%0d]", i), 32'(a_ready), 32'(vecs[i].exp_ready));
      step();
      chk($sformatf("a_dec[%0d]", i), 32'(a_dec), 32'(vecs[i].exp_dec));
      chk($sformatf("a_err[%0d]", i), 32'(a_err), 32'd0);
    end
    a_valid = 0; a_en = 1; a_clear = 0;

    // Instance B: out-of-range code, valid code with sticky err, then clear
    b_valid = 1; b_code = 3'd6; #1;
    chk("b_ready_oor", 32'(b_ready), 32'd1);
    step();
    chk("b_dec_oor", 32'(b_dec), 32'd0);
    chk("b_err_oor", 32'(b_err), 32'd1);
    b_code = 3'd4; #1;
    chk("b_ready_4", 32'(b_ready), 32'd1);
    step();
    chk("b_dec_4", 32'(b_dec), 32'b10000);
    chk("b_err_4", 32'(b_err), 32'd1);
    b_valid = 0; b_clear = 1; #1;
    chk("b_ready_clr", 32'(b_ready), 32'd0);
    step();
    chk("b_dec_clr", 32'(b_dec), 32'd0);
    chk("b_err_clr", 32'(b_err), 32'd0);
    b_clear = 0;

    // Instance C: back-to-back single-cycle strobes
    c_valid = 1; c_code = 2'd0; c_mode = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("c_ready[%0d]", k), 32'(c_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
      step();
      chk($sformatf("c_dec[%0d]", k), 32'(c_dec), (k % 2 == 0) ? 32'd1 : 32'd0);
    end
    c_valid = 0; c_mode = 0;

    // Instance A: asynchronous reset in the middle of a pulse
    a_valid = 1; a_code = 2'd2; a_mode = 1;
    step();
    chk("a_pulse_on", 32'(a_dec), 32'b0100);
    a_valid = 0; a_mode = 0;
    step();
    #2;
    rst_n = 0;
    #1;
    chk("a_async_dec", 32'(a_dec), 32'd0);
    chk("a_async_ov",  32'(a_ov),  32'd0);
    #1;
    rst_n = 1;
    #1;
    chk("a_ready_after_rst", 32'(a_ready), 32'd1);
    step();
    chk("a_dec_after_rst", 32'(a_dec), 32'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
